// File: rtl/commit_writeback_if.sv
// Execute->commit result packet: NUM_ALU ALU lanes plus NUM_BR branch lanes with
// a single valid/ready handshake for the whole packet.
interface commit_writeback_if #(
    parameter int NUM_ALU = 4,
    parameter int NUM_BR  = 1,
    parameter int DST_W   = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_ALU-1:0]        in_alu_valid;
    logic [NUM_ALU*DST_W-1:0]  in_alu_dst;
    logic [NUM_ALU*64-1:0]     in_alu_data;
    logic [NUM_BR-1:0]         in_br_valid;
    logic [NUM_BR*DST_W-1:0]   in_br_dst;
    logic [NUM_BR*64-1:0]      in_br_data;
    logic [NUM_BR*64-1:0]      in_br_extra;

    modport master (
        output in_valid, in_alu_valid, in_alu_dst, in_alu_data,
               in_br_valid, in_br_dst, in_br_data, in_br_extra,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_alu_valid, in_alu_dst, in_alu_data,
               in_br_valid, in_br_dst, in_br_data, in_br_extra,
        output in_ready
    );
endinterface

// File: rtl/commit_writeback.sv
// Commit stage: compacts execute result lanes into an in-order FIFO, drains it to
// the register file WR_PORTS entries per cycle and raises registered branch redirects.
module commit_writeback #(
    parameter int NUM_ALU  = 4,
    parameter int NUM_BR   = 1,
    parameter int WR_PORTS = 2,
    parameter int DEPTH    = 8,
    parameter int DST_W    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    commit_writeback_if.slave         ex,
    output logic [WR_PORTS-1:0]       wr_en,
    output logic [WR_PORTS*DST_W-1:0] wr_addr,
    output logic [WR_PORTS*64-1:0]    wr_data,
    output logic                      redirect_valid,
    output logic [63:0]               redirect_pc
);
    localparam int LANES = NUM_ALU + NUM_BR;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    logic [DST_W-1:0] ent_dst  [DEPTH];
    logic [63:0]      ent_data [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             fire;
    logic [LANES-1:0] lane_ok;
    logic [DST_W-1:0] lane_dst  [LANES];
    logic [63:0]      lane_data [LANES];
    logic [PW-1:0]    lane_slot [LANES];
    logic [CW-1:0]    pushes;
    logic [CW-1:0]    pops;
    logic             redir_hit;
    logic [63:0]      redir_target;

    // Ready looks only at registered occupancy, so it never waits on this cycle's pops.
    assign ex.in_ready = (count <= CW'(DEPTH - LANES));
    assign fire        = ex.in_valid & ex.in_ready;

    always_comb begin
        lane_ok   = '0;
        lane_dst  = '{default: '0};
        lane_data = '{default: '0};
        for (int unsigned j = 0; j < NUM_ALU; j++) begin
            lane_dst[j]  = ex.in_alu_dst[j*DST_W +: DST_W];
            lane_data[j] = ex.in_alu_data[j*64 +: 64];
            lane_ok[j]   = ex.in_alu_valid[j] && (lane_dst[j] != '0);
        end
        for (int unsigned j = 0; j < NUM_BR; j++) begin
            lane_dst[NUM_ALU+j]  = ex.in_br_dst[j*DST_W +: DST_W];
            lane_data[NUM_ALU+j] = ex.in_br_data[j*64 +: 64];
            lane_ok[NUM_ALU+j]   = ex.in_br_valid[j] && (lane_dst[NUM_ALU+j] != '0);
        end
    end

    // Each surviving lane lands at tail plus the number of surviving lanes before it.
    always_comb begin
        pushes    = '0;
        lane_slot = '{default: '0};
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_slot[j] = tail + PW'(pushes);
            if (lane_ok[j]) pushes = pushes + 1'b1;
        end
    end

    assign pops = (count > CW'(WR_PORTS)) ? CW'(WR_PORTS) : count;

    always_comb begin
        redir_hit    = 1'b0;
        redir_target = '0;
        for (int unsigned j = 0; j < NUM_BR; j++) begin
            if (!redir_hit && ex.in_br_valid[j] && (ex.in_br_extra[j*64 +: 64] != '0)) begin
                redir_hit    = 1'b1;
                redir_target = ex.in_br_extra[j*64 +: 64];
            end
        end
    end

    always_comb begin
        logic [PW-1:0] rd_idx;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int unsigned i = 0; i < WR_PORTS; i++) begin
            rd_idx   = head + PW'(i);
            wr_en[i] = (count > CW'(i));
            if (wr_en[i]) begin
                wr_addr[i*DST_W +: DST_W] = ent_dst[rd_idx];
                wr_data[i*64 +: 64]       = ent_data[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            head           <= head + PW'(pops);
            count          <= count + (fire ? pushes : '0) - pops;
            redirect_valid <= fire & redir_hit;
            if (fire) begin
                tail <= tail + PW'(pushes);
                if (redir_hit) redirect_pc <= redir_target;
            end
            for (int unsigned j = 0; j < LANES; j++) begin
                if (fire && lane_ok[j]) begin
                    ent_dst[lane_slot[j]]  <= lane_dst[j];
                    ent_data[lane_slot[j]] <= lane_data[j];
                end
            end
        end
    end
endmodule

// File: tb/tb_commit_writeback.sv
// Directed bench for commit_writeback: hand-computed write/redirect sequences plus
// a queue scoreboard for the back-to-back wraparound run.
module tb_commit_writeback;
    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commit_writeback_if #(.NUM_ALU(4), .NUM_BR(1), .DST_W(5)) ex ();

    commit_writeback #(
        .NUM_ALU(4), .NUM_BR(1), .WR_PORTS(2), .DEPTH(8), .DST_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ex(ex),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ex.in_valid     = 1'b0;
        ex.in_alu_valid = '0;
        ex.in_alu_dst   = '0;
        ex.in_alu_data  = '0;
        ex.in_br_valid  = '0;
        ex.in_br_dst    = '0;
        ex.in_br_data   = '0;
        ex.in_br_extra  = '0;
    endtask

    task automatic alu(input int j, input logic [4:0] d, input logic [63:0] v);
        ex.in_alu_valid[j]       = 1'b1;
        ex.in_alu_dst[j*5 +: 5]  = d;
        ex.in_alu_data[j*64 +: 64] = v;
    endtask

    task automatic br(input logic [4:0] d, input logic [63:0] v, input logic [63:0] x);
        ex.in_br_valid = 1'b1;
        ex.in_br_dst   = d;
        ex.in_br_data  = v;
        ex.in_br_extra = x;
    endtask

    // Disabled ports are expected to read back as zero.
    task automatic wr(input string tag, input logic [1:0] en,
                      input logic [4:0] a0, input logic [63:0] d0,
                      input logic [4:0] a1, input logic [63:0] d1);
        chk({tag, " wr_en"}, 64'(wr_en), 64'(en));
        chk({tag, " addr0"}, 64'(wr_addr[4:0]), 64'(a0));
        chk({tag, " data0"}, wr_data[63:0], d0);
        chk({tag, " addr1"}, 64'(wr_addr[9:5]), 64'(a1));
        chk({tag, " data1"}, wr_data[127:64], d1);
    endtask

    function automatic logic [4:0] t3_dst(input int n, input int j);
        return 5'(((n * 5 + j) % 31) + 1);
    endfunction

    function automatic logic [63:0] t3_data(input int n, input int j);
        return 64'h1000 + 64'(n * 16 + j);
    endfunction

    logic [4:0]  qd[$];
    logic [63:0] qv[$];
    int          sent;
    int          cyc;
    logic        exp_ready;

    initial begin
        clr();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst wr_en", 64'(wr_en), 0);
        chk("rst redirect_valid", 64'(redirect_valid), 0);
        chk("rst redirect_pc", redirect_pc, 0);
        chk("rst in_ready", 64'(ex.in_ready), 1);

        // Test 1: four ALU lanes drained two per cycle
        ex.in_valid = 1'b1;
        alu(0, 5'd1, 64'hA); alu(1, 5'd2, 64'hB); alu(2, 5'd3, 64'hC); alu(3, 5'd4, 64'hD);
        step();
        clr();
        wr("t1 c1", 2'b11, 5'd1, 64'hA, 5'd2, 64'hB);
        chk("t1 ready count4", 64'(ex.in_ready), 0);
        step();
        wr("t1 c2", 2'b11, 5'd3, 64'hC, 5'd4, 64'hD);
        chk("t1 ready count2", 64'(ex.in_ready), 1);
        step();
        wr("t1 c3", 2'b00, 5'd0, 0, 5'd0, 0);

        // Test 2: dst==0 and invalid lanes dropped
        ex.in_valid = 1'b1;
        alu(0, 5'd5, 64'h55); alu(1, 5'd0, 64'h66); alu(3, 5'd7, 64'h77);
        ex.in_alu_dst[14:10] = 5'd6;
        ex.in_alu_data[191:128] = 64'h99;
        step();
        clr();
        wr("t2 c1", 2'b11, 5'd5, 64'h55, 5'd7, 64'h77);
        step();
        wr("t2 c2", 2'b00, 5'd0, 0, 5'd0, 0);

        // Test 4: branch redirect pulse, hold, no-redirect and dst==0 redirect
        ex.in_valid = 1'b1;
        br(5'd1, 64'h104, 64'h2000);
        step();
        clr();
        chk("t4 rv", 64'(redirect_valid), 1);
        chk("t4 rpc", redirect_pc, 64'h2000);
        wr("t4 link", 2'b01, 5'd1, 64'h104, 5'd0, 0);
        step();
        chk("t4 rv pulse end", 64'(redirect_valid), 0);
        chk("t4 rpc hold", redirect_pc, 64'h2000);
        wr("t4 idle", 2'b00, 5'd0, 0, 5'd0, 0);
        ex.in_valid = 1'b1;
        br(5'd2, 64'h108, 64'h0);
        step();
        clr();
        chk("t4 extra0 rv", 64'(redirect_valid), 0);
        chk("t4 extra0 rpc", redirect_pc, 64'h2000);
        wr("t4 extra0", 2'b01, 5'd2, 64'h108, 5'd0, 0);
        step();
        ex.in_valid = 1'b1;
        br(5'd0, 64'h1, 64'h3000);
        step();
        clr();
        chk("t4 dst0 rv", 64'(redirect_valid), 1);
        chk("t4 dst0 rpc", redirect_pc, 64'h3000);
        wr("t4 dst0", 2'b00, 5'd0, 0, 5'd0, 0);
        step();
        chk("t4 dst0 rv end", 64'(redirect_valid), 0);

        // Test 5: packet held while not ready, accepted once ready
        ex.in_valid = 1'b1;
        alu(0, 5'd1, 64'h11); alu(1, 5'd2, 64'h12); alu(2, 5'd3, 64'h13); alu(3, 5'd4, 64'h14);
        br(5'd5, 64'h15, 64'h0);
        step();
        chk("t5 ready5", 64'(ex.in_ready), 0);
        wr("t5 c1", 2'b11, 5'd1, 64'h11, 5'd2, 64'h12);
        clr();
        ex.in_valid = 1'b1;
        alu(0, 5'd8, 64'h88); alu(1, 5'd9, 64'h89); alu(2, 5'd10, 64'h8a); alu(3, 5'd11, 64'h8b);
        br(5'd12, 64'h8c, 64'h4000);
        step();
        chk("t5 stalled rv", 64'(redirect_valid), 0);
        chk("t5 ready3", 64'(ex.in_ready), 1);
        wr("t5 c2", 2'b11, 5'd3, 64'h13, 5'd4, 64'h14);
        step();
        clr();
        chk("t5 rv", 64'(redirect_valid), 1);
        chk("t5 rpc", redirect_pc, 64'h4000);
        chk("t5 ready6", 64'(ex.in_ready), 0);
        wr("t5 c3", 2'b11, 5'd5, 64'h15, 5'd8, 64'h88);
        step();
        chk("t5 rv end", 64'(redirect_valid), 0);
        wr("t5 c4", 2'b11, 5'd9, 64'h89, 5'd10, 64'h8a);
        step();
        wr("t5 c5", 2'b11, 5'd11, 64'h8b, 5'd12, 64'h8c);
        step();
        wr("t5 c6", 2'b00, 5'd0, 0, 5'd0, 0);

        // Test 3: 20 back-to-back full packets across pointer wraps
        sent = 0;
        cyc  = 0;
        while ((sent < 20 || qd.size() > 0) && cyc < 300) begin
            for (int i = 0; i < 2; i++) begin
                if (qd.size() > i) begin
                    chk("t3 wr_en", 64'(wr_en[i]), 1);
                    chk("t3 addr", 64'(wr_addr[i*5 +: 5]), 64'(qd[i]));
                    chk("t3 data", wr_data[i*64 +: 64], qv[i]);
                end else begin
                    chk("t3 wr_en idle", 64'(wr_en[i]), 0);
                end
            end
            exp_ready = (qd.size() <= 3);
            chk("t3 in_ready", 64'(ex.in_ready), 64'(exp_ready));
            for (int i = 0; i < 2; i++) begin
                if (qd.size() > 0) begin
                    void'(qd.pop_front());
                    void'(qv.pop_front());
                end
            end
            clr();
            if (sent < 20) begin
                ex.in_valid = 1'b1;
                for (int j = 0; j < 4; j++) alu(j, t3_dst(sent, j), t3_data(sent, j));
                br(t3_dst(sent, 4), t3_data(sent, 4), 64'h0);
                if (exp_ready) begin
                    for (int j = 0; j < 5; j++) begin
                        qd.push_back(t3_dst(sent, j));
                        qv.push_back(t3_data(sent, j));
                    end
                    sent++;
                end
            end
            step();
            cyc++;
        end
        clr();
        chk("t3 all sent", 64'(sent), 20);
        chk("t3 drained", 64'(qd.size()), 0);
        chk("t3 no redirect", 64'(redirect_valid), 0);

        // Test 6: reset with six entries queued
        ex.in_valid = 1'b1;
        alu(0, 5'd1, 64'h61); alu(1, 5'd2, 64'h62); alu(2, 5'd3, 64'h63); alu(3, 5'd4, 64'h64);
        br(5'd5, 64'h65, 64'h0);
        step();
        clr();
        step();
        ex.in_valid = 1'b1;
        alu(0, 5'd6, 64'h66); alu(1, 5'd7, 64'h67); alu(2, 5'd8, 64'h68); alu(3, 5'd9, 64'h69);
        br(5'd10, 64'h6a, 64'h5000);
        step();
        clr();
        chk("t6 pre rv", 64'(redirect_valid), 1);
        chk("t6 pre ready", 64'(ex.in_ready), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wr("t6 rst", 2'b00, 5'd0, 0, 5'd0, 0);
        chk("t6 ready", 64'(ex.in_ready), 1);
        chk("t6 rv", 64'(redirect_valid), 0);
        chk("t6 rpc", redirect_pc, 0);
        step();
        wr("t6 discarded", 2'b00, 5'd0, 0, 5'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
